// File: rtl/demultiplexor16_wb.sv
// Registered 1-to-16 write demultiplexor. It routes one data word into one of 16
// held channels and gives each channel a pending flag, a one-cycle strobe and a sticky overflow flag.

module demux16_chan #(
    parameter int WIDTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             stb_o,
    output logic             pend_o,
    output logic             ovr_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             stb_q, stb_d, pend_q, pend_d, ovr_q, ovr_d;

    always_comb begin
        data_d = data_q;
        stb_d  = wr_i;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (wr_i) begin
            data_d = data_i;
            pend_d = 1'b1;
            // An overwrite with a simultaneous ack means the old value was consumed.
            if (pend_q) ovr_d = OVERWRITE && !ack_i;
        end else if (ack_i && pend_q) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (!OVERWRITE) ovr_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            stb_q  <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            stb_q  <= stb_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_o = data_q;
    assign stb_o  = stb_q;
    assign pend_o = pend_q;
    assign ovr_o  = ovr_q;
endmodule

module demultiplexor16_wb #(
    parameter int WIDTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [3:0]       sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out0_o,
    output logic [WIDTH-1:0] out1_o,
    output logic [WIDTH-1:0] out2_o,
    output logic [WIDTH-1:0] out3_o,
    output logic [WIDTH-1:0] out4_o,
    output logic [WIDTH-1:0] out5_o,
    output logic [WIDTH-1:0] out6_o,
    output logic [WIDTH-1:0] out7_o,
    output logic [WIDTH-1:0] out8_o,
    output logic [WIDTH-1:0] out9_o,
    output logic [WIDTH-1:0] out10_o,
    output logic [WIDTH-1:0] out11_o,
    output logic [WIDTH-1:0] out12_o,
    output logic [WIDTH-1:0] out13_o,
    output logic [WIDTH-1:0] out14_o,
    output logic [WIDTH-1:0] out15_o,
    output logic [15:0]      out_stb_o,
    output logic [15:0]      out_pend_o,
    input  logic [15:0]      out_ack_i,
    output logic [15:0]      out_ovr_o
);
    logic [15:0][WIDTH-1:0] data;
    logic                   accept;

    assign in_ready_o = !rst_i && (OVERWRITE || !out_pend_o[sel_i]);
    assign accept     = in_valid_i && in_ready_o;

    for (genvar i = 0; i < 16; i++) begin : g_chan
        demux16_chan #(.WIDTH(WIDTH), .OVERWRITE(OVERWRITE)) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .wr_i   (accept && (sel_i == 4'(i))),
            .ack_i  (out_ack_i[i]),
            .data_i (in_i),
            .data_o (data[i]),
            .stb_o  (out_stb_o[i]),
            .pend_o (out_pend_o[i]),
            .ovr_o  (out_ovr_o[i])
        );
    end

    assign out0_o  = data[0];
    assign out1_o  = data[1];
    assign out2_o  = data[2];
    assign out3_o  = data[3];
    assign out4_o  = data[4];
    assign out5_o  = data[5];
    assign out6_o  = data[6];
    assign out7_o  = data[7];
    assign out8_o  = data[8];
    assign out9_o  = data[9];
    assign out10_o = data[10];
    assign out11_o = data[11];
    assign out12_o = data[12];
    assign out13_o = data[13];
    assign out14_o = data[14];
    assign out15_o = data[15];
endmodule

// File: doc/demultiplexor16_wb.md
Name: demultiplexor16_wb

Overview:
- Registered 1-to-16 demultiplexor, the write-side counterpart of the 16-input read multiplexor.
- Routes one incoming data word to one of 16 held output channels chosen by SEL.
- Gives each channel a pending flag, a one-cycle write strobe and an acknowledge.
- Sits between a producer (ALU or write-back stage) and up to 16 consumers or register slots. The consumers' values are later read back through the 16-way multiplexor.

Parameters:
- WIDTH, 16, data width of IN and of each OUTn.
- OVERWRITE, 0. 0 = back-pressure on a pending channel. 1 = always accept, overwrite the pending value and flag the overflow.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN  input  WIDTH  data word to route.
- SEL  input  4  destination channel index, 0..15.
- IN_VALID  input  1  producer offers IN/SEL this cycle.
- IN_READY  output  1  block accepts IN/SEL this cycle (combinational).
- OUT0..OUT15  output  WIDTH each  held registered value of each channel.
- OUT_STB  output  16  bit i pulses high for one cycle after channel i is written.
- OUT_PEND  output  16  bit i high while channel i holds an unacknowledged value.
- OUT_ACK  input  16  bit i from consumer i; clears OUT_PEND[i].
- OUT_OVR  output  16  bit i sticky: a pending value on channel i was overwritten. Only used when OVERWRITE=1; otherwise held 0.

Behaviour:
- Reset (RST=1 at rising edge): all OUTn=0, OUT_STB=0, OUT_PEND=0, OUT_OVR=0. IN_READY=0 while RST=1. Reset mid-transfer discards the transfer; no channel is updated on that edge.
- IN_READY:
  - OVERWRITE=0: IN_READY = !RST & !OUT_PEND[SEL].
  - OVERWRITE=1: IN_READY = !RST.
- Accept = IN_VALID & IN_READY, sampled at the rising edge. Latency is one cycle. On the edge where accept occurs:
  - OUTsel <= IN.
  - OUT_PEND[SEL] <= 1.
  - OUT_STB[SEL] <= 1 for exactly one cycle.
  - All other channels keep their OUTn value.
- OUT_STB is all-zero on any cycle that does not follow an accept. At most one bit is set at a time.
- OUT_ACK[i] with OUT_PEND[i]=1 and no accept to channel i: OUT_PEND[i] <= 0 and OUT_OVR[i] <= 0 next cycle. OUTi keeps its value; data is never cleared by ACK.
- OUT_ACK[i] with OUT_PEND[i]=0: ignored, unless it coincides with an accept to channel i, in which case the write wins and PEND becomes 1.
- Several OUT_ACK bits may be high together; each is handled independently.
- Accept to channel i while OUT_PEND[i]=1, possible only with OVERWRITE=1:
  - Without OUT_ACK[i]: OUTi <= IN, PEND stays 1, OUT_OVR[i] <= 1.
  - With OUT_ACK[i] in the same cycle: the old value is consumed, so PEND=1, OUT_OVR[i] <= 0, OUTi <= IN, and OUT_STB[i] pulses.
- SEL and IN are ignored when IN_VALID=0.
- SEL and IN may change every cycle. Back-to-back accepts to different channels sustain one word per cycle.
- No internal state machine beyond the per-channel PEND/OVR/STB flags. There are 16 independent 2-state channels (IDLE, PEND) plus the OVR flag.
- No arithmetic; widths are exact, with no truncation or extension.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then release with IN_VALID=0 -> all OUTn=0, OUT_STB=0, OUT_PEND=0, IN_READY=1.
- Single route (OVERWRITE=0): IN=16'hA5A5, SEL=7, IN_VALID=1 for 1 cycle.
  - Next cycle: OUT7=A5A5, OUT_STB=16'h0080 for one cycle, OUT_PEND=16'h0080; all other OUTn=0.
  - OUT_ACK[7]=1 for 1 cycle -> OUT_PEND=0, OUT7 still A5A5.
- Back-pressure (OVERWRITE=0): channel 3 pending, then IN=16'h1234, SEL=3, IN_VALID=1 held.
  - IN_READY=0 and OUT3 unchanged until OUT_ACK[3] is pulsed.
  - IN_READY rises the cycle after ACK, and OUT3=1234 one cycle after that.
- Streaming: SEL=0..15 on 16 consecutive cycles, IN=16'h1000+SEL, all channels initially idle.
  - Every cycle accepted; OUTn=16'h1000+n.
  - OUT_STB walks one-hot 0001 to 8000, and OUT_PEND=16'hFFFF at the end.
- Overwrite mode (OVERWRITE=1):
  - Write SEL=5 IN=1111, then SEL=5 IN=2222 without ACK -> OUT5=2222, OUT_OVR[5]=1, OUT_PEND[5]=1.
  - Repeat with OUT_ACK[5] asserted on the second write -> OUT_OVR[5]=0.
- Reset mid-operation: assert RST on the same edge as an accept to SEL=9 with channel 2 pending -> OUT9=0, OUT_PEND=0, OUT_STB=0 the next cycle.
